// File: rtl/l2_cache_ctrl_nway.sv
// N-way set-associative L2 control unit: tree pseudo-LRU, invalid-first victim choice, dirty write-back.
// Define L2_PERF_CNT_EN to build the hit/miss/write-back event counters; otherwise perf_* read 0.
module l2_cache_ctrl_nway #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16,
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int SET_W = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                mem_resp,
    input  logic [SET_W-1:0]    set_idx,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp,
    input  logic [NUM_WAYS-1:0] way_hit,
    input  logic [NUM_WAYS-1:0] way_valid,
    input  logic [NUM_WAYS-1:0] way_dirty,
    output logic [NUM_WAYS-1:0] tag_load,
    output logic [NUM_WAYS-1:0] valid_load,
    output logic [NUM_WAYS-1:0] dirty_load,
    output logic                dirty_in,
    output logic [1:0]          writing,
    output logic [WAY_W-1:0]    data_way,
    output logic                pmem_addr_sel,
    output logic [31:0]         perf_hits,
    output logic [31:0]         perf_misses,
    output logic [31:0]         perf_writebacks,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CHECK     = 2'd1,
        S_WRITEBACK = 2'd2,
        S_FETCH     = 2'd3
    } state_t;

    typedef logic [NUM_WAYS-2:0] plru_t;

    localparam int             TREE_W    = 2 * NUM_WAYS;
    localparam logic [WAY_W:0] LEAF_BASE = (WAY_W + 1)'(NUM_WAYS - 1);
    localparam logic [NUM_WAYS-1:0] WAY_ONE = {{(NUM_WAYS - 1){1'b0}}, 1'b1};

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_CPU  = 2'b01;
    localparam logic [1:0] WR_FILL = 2'b10;

    // The tree is padded to a power-of-two width so a heap node number indexes it directly.
    function automatic logic [WAY_W-1:0] plru_victim(input plru_t bits);
        logic [TREE_W-1:0] tree;
        logic [WAY_W:0]    node;
        logic [WAY_W:0]    leaf;
        tree = {{(NUM_WAYS + 1){1'b0}}, bits};
        node = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            node = (node << 1) + (WAY_W + 1)'(1) + (WAY_W + 1)'(tree[node]);
        end
        leaf = node - LEAF_BASE;
        return leaf[WAY_W-1:0];
    endfunction

    // Every node on the accessed way's path is made to point at the other half.
    function automatic plru_t plru_touch(input plru_t bits, input logic [WAY_W-1:0] way);
        logic [TREE_W-1:0] tree;
        logic [WAY_W:0]    node;
        logic [WAY_W-1:0]  path;
        logic              dir;
        tree = {{(NUM_WAYS + 1){1'b0}}, bits};
        node = '0;
        path = way;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir        = path[WAY_W-1];
            tree[node] = ~dir;
            node       = (node << 1) + (WAY_W + 1)'(1) + (WAY_W + 1)'(dir);
            path       = path << 1;
        end
        return tree[NUM_WAYS-2:0];
    endfunction

    state_t           state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    plru_t            plru_q [NUM_SETS];
    plru_t            plru_d [NUM_SETS];

    logic             req;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic             any_invalid;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] miss_victim;
    logic             victim_dirty;

    assign req         = mem_read | mem_write;
    assign hit_any     = |way_hit;
    assign any_invalid = ~&way_valid;
    assign state_dbg   = state_q;

    // Lowest index wins for both the hit way and the first invalid way.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_way = WAY_W'(i);
            end
            if (!way_valid[i]) begin
                inv_way = WAY_W'(i);
            end
        end
    end

    assign miss_victim  = any_invalid ? inv_way : plru_victim(plru_q[set_idx]);
    assign victim_dirty = way_valid[miss_victim] & way_dirty[miss_victim];

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        plru_d        = plru_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        tag_load      = '0;
        valid_load    = '0;
        dirty_load    = '0;
        dirty_in      = 1'b0;
        writing       = WR_NONE;
        data_way      = '0;
        pmem_addr_sel = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (hit_any) begin
                    mem_resp         = 1'b1;
                    data_way         = hit_way;
                    plru_d[set_idx]  = plru_touch(plru_q[set_idx], hit_way);
                    state_d          = S_IDLE;
                    // A simultaneous read and write is handled as a write.
                    if (mem_write) begin
                        writing    = WR_CPU;
                        dirty_load = WAY_ONE << hit_way;
                        dirty_in   = 1'b1;
                    end
                end else begin
                    victim_d = miss_victim;
                    state_d  = victim_dirty ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                data_way      = victim_q;
                if (pmem_resp) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                pmem_read = 1'b1;
                data_way  = victim_q;
                if (pmem_resp) begin
                    writing    = WR_FILL;
                    tag_load   = WAY_ONE << victim_q;
                    valid_load = WAY_ONE << victim_q;
                    dirty_load = WAY_ONE << victim_q;
                    state_d    = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            plru_q   <= plru_d;
        end
    end

`ifdef L2_PERF_CNT_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;
    logic [31:0] wbs_q, wbs_d;
    logic        refill_q, refill_d;

    // refill marks the re-check that follows a fill so its hit is not counted twice.
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        wbs_d    = wbs_q;
        refill_d = refill_q;
        if (state_q == S_FETCH && pmem_resp) begin
            refill_d = 1'b1;
        end else if (state_q == S_CHECK) begin
            refill_d = 1'b0;
        end
        if (state_q == S_CHECK && req) begin
            if (hit_any) begin
                if (!refill_q) begin
                    hits_d = hits_q + 32'd1;
                end
            end else begin
                misses_d = misses_q + 32'd1;
            end
        end
        if (state_q != S_WRITEBACK && state_d == S_WRITEBACK) begin
            wbs_d = wbs_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
            refill_q <= 1'b0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            wbs_q    <= wbs_d;
            refill_q <= refill_d;
        end
    end

    assign perf_hits       = hits_q;
    assign perf_misses     = misses_q;
    assign perf_writebacks = wbs_q;
`else
    assign perf_hits       = '0;
    assign perf_misses     = '0;
    assign perf_writebacks = '0;
`endif

endmodule

// File: tb/tb_l2_cache_ctrl_nway.sv
// Directed bench for l2_cache_ctrl_nway (4 ways, 16 sets): hits, fills, write-back, PLRU order, reset.
module tb_l2_cache_ctrl_nway;

    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 16;
    localparam int WAY_W    = 2;
    localparam int SET_W    = 4;

`ifdef L2_PERF_CNT_EN
    localparam logic [31:0] EXP_HITS = 32'd3;
    localparam logic [31:0] EXP_MISS = 32'd2;
    localparam logic [31:0] EXP_WB   = 32'd1;
`else
    localparam logic [31:0] EXP_HITS = 32'd0;
    localparam logic [31:0] EXP_MISS = 32'd0;
    localparam logic [31:0] EXP_WB   = 32'd0;
`endif

    logic                clk;
    logic                rst;
    logic                mem_read;
    logic                mem_write;
    logic                mem_resp;
    logic [SET_W-1:0]    set_idx;
    logic                pmem_read;
    logic                pmem_write;
    logic                pmem_resp;
    logic [NUM_WAYS-1:0] way_hit;
    logic [NUM_WAYS-1:0] way_valid;
    logic [NUM_WAYS-1:0] way_dirty;
    logic [NUM_WAYS-1:0] tag_load;
    logic [NUM_WAYS-1:0] valid_load;
    logic [NUM_WAYS-1:0] dirty_load;
    logic                dirty_in;
    logic [1:0]          writing;
    logic [WAY_W-1:0]    data_way;
    logic                pmem_addr_sel;
    logic [31:0]         perf_hits;
    logic [31:0]         perf_misses;
    logic [31:0]         perf_writebacks;
    logic [1:0]          state_dbg;

    int n_total = 0;
    int n_bad   = 0;
    logic [WAY_W-1:0] exp_q[$];

    l2_cache_ctrl_nway #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .set_idx(set_idx),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
        .tag_load(tag_load), .valid_load(valid_load), .dirty_load(dirty_load),
        .dirty_in(dirty_in), .writing(writing), .data_way(data_way),
        .pmem_addr_sel(pmem_addr_sel),
        .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_writebacks(perf_writebacks),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        way_hit   = '0;
        pmem_resp = 1'b0;
    endtask

    // Runs one request from IDLE, answering pmem at once and hitting the filled way on re-check.
    task automatic txn(input logic wr, input logic [SET_W-1:0] s, input logic [3:0] hit,
                       input logic [3:0] valid, input logic [3:0] dirty,
                       output int lat, output logic [WAY_W-1:0] vic);
        bit done;
        bit filled;
        done      = 0;
        lat       = -1;
        vic       = '0;
        mem_read  = ~wr;
        mem_write = wr;
        set_idx   = s;
        way_hit   = hit;
        way_valid = valid;
        way_dirty = dirty;
        for (int c = 0; c < 40 && !done; c++) begin
            filled    = 0;
            pmem_resp = pmem_read | pmem_write;
            #1;
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (valid_load[w]) begin
                    vic    = WAY_W'(w);
                    filled = 1;
                end
            end
            if (mem_resp) begin
                done = 1;
                lat  = c;
            end
            tick();
            if (filled) way_hit = 4'b0001 << vic;
        end
        clear_req();
        chk("txn_done", 32'(done), 32'd1);
    endtask

    initial begin : main
        int               lat;
        logic [WAY_W-1:0] vic;

        rst       = 1'b1;
        set_idx   = '0;
        way_valid = '0;
        way_dirty = '0;
        clear_req();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_resp", 32'(mem_resp), 32'd0);
        chk("rst_pmem", 32'({pmem_read, pmem_write}), 32'd0);
        chk("rst_perf", perf_hits | perf_misses | perf_writebacks, 32'd0);
        rst = 1'b0;
        tick();

        // read hit, way 2 of set 3
        mem_read = 1'b1; set_idx = 4'd3; way_hit = 4'b0100; way_valid = 4'hF; way_dirty = 4'h0;
        #1;
        chk("hit_c0_resp", 32'(mem_resp), 32'd0);
        tick();
        chk("hit_resp", 32'(mem_resp), 32'd1);
        chk("hit_way", 32'(data_way), 32'd2);
        chk("hit_pmem", 32'({pmem_read, pmem_write}), 32'd0);
        chk("hit_strobes", 32'({writing, dirty_load, valid_load}), 32'd0);
        tick();
        clear_req();
        #1;
        chk("hit_back_idle", 32'(state_dbg), 32'd0);
        tick();

        // write hit, way 1 of set 4
        mem_write = 1'b1; set_idx = 4'd4; way_hit = 4'b0010;
        tick();
        chk("wr_writing", 32'(writing), 32'b01);
        chk("wr_dirty_load", 32'(dirty_load), 32'b0010);
        chk("wr_dirty_in", 32'(dirty_in), 32'd1);
        chk("wr_resp", 32'(mem_resp), 32'd1);
        chk("wr_no_tag_load", 32'({tag_load, valid_load}), 32'd0);
        tick();
        clear_req();

        // set 3: touch way 0 after way 2 -> b0=1,b1=1,b2=1 -> victim 3
        txn(1'b0, 4'd3, 4'b0001, 4'hF, 4'h0, lat, vic);
        chk("hit2_lat", 32'(lat), 32'd1);
        txn(1'b0, 4'd3, 4'b0000, 4'hF, 4'h0, lat, vic);
        chk("plru_b2_kept", 32'(vic), 32'd3);
        chk("clean_miss_lat", 32'(lat), 32'd3);

        // invalid-first miss, set 5, way 2 invalid (its dirty bit must be ignored)
        mem_read = 1'b1; set_idx = 4'd5; way_hit = 4'b0000; way_valid = 4'b1011; way_dirty = 4'hF;
        tick();
        chk("inv_check_resp", 32'(mem_resp), 32'd0);
        tick();
        chk("inv_state_fetch", 32'(state_dbg), 32'd3);
        chk("inv_fetch_pmem", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'b100);
        pmem_resp = 1'b1;
        #1;
        chk("inv_fill_writing", 32'(writing), 32'b10);
        chk("inv_fill_loads", 32'({tag_load, valid_load, dirty_load}), 32'h444);
        chk("inv_fill_dirty_in", 32'(dirty_in), 32'd0);
        tick();
        pmem_resp = 1'b0; way_hit = 4'b0100;
        #1;
        chk("inv_recheck_resp", 32'(mem_resp), 32'd1);
        chk("inv_recheck_pmem", 32'(pmem_read), 32'd0);
        tick();
        clear_req();

        // dirty miss, set 6 untouched -> victim 0, write-back held 5 cycles
        mem_read = 1'b1; set_idx = 4'd6; way_valid = 4'hF; way_dirty = 4'hF;
        tick();
        chk("wb_check_resp", 32'(mem_resp), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            pmem_resp = (i == 4);
            #1;
            chk("wb_hold", 32'({pmem_write, pmem_read, pmem_addr_sel, data_way}), 32'b10100);
            tick();
        end
        pmem_resp = 1'b0;
        #1;
        chk("wb_to_fetch", 32'({pmem_write, pmem_read, pmem_addr_sel}), 32'b010);
        pmem_resp = 1'b1;
        #1;
        chk("wb_fill_valid_load", 32'(valid_load), 32'b0001);
        tick();
        pmem_resp = 1'b0; way_hit = 4'b0001;
        #1;
        chk("wb_recheck_resp", 32'(mem_resp), 32'd1);
        tick();
        clear_req();

        // scoreboard: four misses to a fresh set, all valid and clean
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        while (exp_q.size() > 0) begin
            txn(1'b0, 4'd7, 4'b0000, 4'hF, 4'h0, lat, vic);
            chk("plru_order", 32'(vic), 32'(exp_q.pop_front()));
        end

        // asynchronous reset in the middle of FETCH
        mem_read = 1'b1; set_idx = 4'd8; way_hit = 4'b0000; way_valid = 4'b0111; way_dirty = 4'h0;
        tick();
        tick();
        chk("pre_rst_pmem_read", 32'(pmem_read), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_fetch_pmem_read", 32'(pmem_read), 32'd0);
        chk("rst_fetch_state", 32'(state_dbg), 32'd0);
        chk("rst_fetch_perf", perf_hits | perf_misses | perf_writebacks, 32'd0);
        clear_req();
        tick();
        rst = 1'b0;
        tick();

        // PLRU of set 3 was non-zero before reset; reset must bring it back to victim 0
        txn(1'b0, 4'd3, 4'b0000, 4'hF, 4'h0, lat, vic);
        chk("plru_after_rst", 32'(vic), 32'd0);
        txn(1'b0, 4'd1, 4'b0001, 4'hF, 4'h0, lat, vic);
        txn(1'b0, 4'd1, 4'b0010, 4'hF, 4'h0, lat, vic);
        txn(1'b1, 4'd2, 4'b1000, 4'hF, 4'h0, lat, vic);
        chk("wr_hit_lat", 32'(lat), 32'd1);
        txn(1'b0, 4'd9, 4'b0000, 4'hF, 4'hF, lat, vic);
        chk("dirty_miss_vic", 32'(vic), 32'd0);
        chk("dirty_miss_lat", 32'(lat), 32'd4);
        chk("perf_hits", perf_hits, EXP_HITS);
        chk("perf_misses", perf_misses, EXP_MISS);
        chk("perf_writebacks", perf_writebacks, EXP_WB);

        // final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
